// File: rtl/id_ex_register.sv
// ID/EX pipeline register with LDM immediate capture.
// An LDM (flush_in=1 in RUN) parks its control bundle and register indices,
// emits a bubble, and on the following edge pairs them with the next fetched
// word as the immediate. Two-state FSM: RUN / WAIT_IMM.
// Optional feature: define ID_EX_STALL_EN to add the stall input, which
// freezes state, hold registers and outputs while high.
module id_ex_register #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ID_EX_STALL_EN
  input  logic              stall,
`endif
  input  logic              flush_in,
  input  logic [6:0]        EX_in,
  input  logic [3:0]        MEM_in,
  input  logic [2:0]        WB_in,
  input  logic [DATA_W-1:0] rdata1_in,
  input  logic [DATA_W-1:0] rdata2_in,
  input  logic [2:0]        rdst_in,
  input  logic [2:0]        rsrc_in,
  input  logic [DATA_W-1:0] instr_in,
  output logic [6:0]        EX_out,
  output logic [3:0]        MEM_out,
  output logic [2:0]        WB_out,
  output logic [DATA_W-1:0] rdata1_out,
  output logic [DATA_W-1:0] rdata2_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [2:0]        rdst_out,
  output logic [2:0]        rsrc_out,
  output logic              valid_out,
  output logic              imm_wait
);

  typedef enum logic {RUN = 1'b0, WAIT_IMM = 1'b1} state_t;

  state_t state, state_nxt;
  logic   adv;

  // LDM fields parked while the immediate word is fetched
  logic [6:0] ex_hold;
  logic [3:0] mem_hold;
  logic [2:0] wb_hold;
  logic [2:0] rdst_hold;
  logic [2:0] rsrc_hold;

  // next values of the registered outputs
  logic [6:0]        ex_nxt;
  logic [3:0]        mem_nxt;
  logic [2:0]        wb_nxt;
  logic [DATA_W-1:0] rdata1_nxt;
  logic [DATA_W-1:0] rdata2_nxt;
  logic [DATA_W-1:0] imm_nxt;
  logic [2:0]        rdst_nxt;
  logic [2:0]        rsrc_nxt;
  logic              valid_nxt;

`ifdef ID_EX_STALL_EN
  assign adv = ~stall;
`else
  assign adv = 1'b1;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // next-state: LDM in RUN parks for one edge, WAIT_IMM always returns
  always_comb begin
    state_nxt = state;
    if (adv) begin
      unique case (state)
        RUN:      if (flush_in) state_nxt = WAIT_IMM;
        WAIT_IMM: state_nxt = RUN;
        default:  state_nxt = RUN;
      endcase
    end
  end

  // output next-values: pass-through, bubble, or held LDM plus immediate
  always_comb begin
    ex_nxt     = EX_out;
    mem_nxt    = MEM_out;
    wb_nxt     = WB_out;
    rdata1_nxt = rdata1_out;
    rdata2_nxt = rdata2_out;
    imm_nxt    = imm_out;
    rdst_nxt   = rdst_out;
    rsrc_nxt   = rsrc_out;
    valid_nxt  = valid_out;
    if (adv) begin
      unique case (state)
        RUN: begin
          if (flush_in) begin
            // bubble: all-zero control can never write a register or memory
            ex_nxt    = '0;
            mem_nxt   = '0;
            wb_nxt    = '0;
            valid_nxt = 1'b0;
          end else begin
            ex_nxt     = EX_in;
            mem_nxt    = MEM_in;
            wb_nxt     = WB_in;
            rdata1_nxt = rdata1_in;
            rdata2_nxt = rdata2_in;
            rdst_nxt   = rdst_in;
            rsrc_nxt   = rsrc_in;
            valid_nxt  = 1'b1;
          end
        end
        WAIT_IMM: begin
          // current decode bundle is the immediate word decoded as garbage
          ex_nxt     = ex_hold;
          mem_nxt    = mem_hold;
          wb_nxt     = wb_hold;
          rdata1_nxt = '0;
          rdata2_nxt = '0;
          imm_nxt    = instr_in;
          rdst_nxt   = rdst_hold;
          rsrc_nxt   = rsrc_hold;
          valid_nxt  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // hold registers capture the LDM bundle on its accepting edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_hold   <= '0;
      mem_hold  <= '0;
      wb_hold   <= '0;
      rdst_hold <= '0;
      rsrc_hold <= '0;
    end else if (adv && state == RUN && flush_in) begin
      ex_hold   <= EX_in;
      mem_hold  <= MEM_in;
      wb_hold   <= WB_in;
      rdst_hold <= rdst_in;
      rsrc_hold <= rsrc_in;
    end
  end

  // output registers toward execute
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      EX_out     <= '0;
      MEM_out    <= '0;
      WB_out     <= '0;
      rdata1_out <= '0;
      rdata2_out <= '0;
      imm_out    <= '0;
      rdst_out   <= '0;
      rsrc_out   <= '0;
      valid_out  <= 1'b0;
      imm_wait   <= 1'b0;
    end else begin
      EX_out     <= ex_nxt;
      MEM_out    <= mem_nxt;
      WB_out     <= wb_nxt;
      rdata1_out <= rdata1_nxt;
      rdata2_out <= rdata2_nxt;
      imm_out    <= imm_nxt;
      rdst_out   <= rdst_nxt;
      rsrc_out   <= rsrc_nxt;
      valid_out  <= valid_nxt;
      imm_wait   <= (state_nxt == WAIT_IMM);
    end
  end

endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: directed scenarios followed by random traffic,
// checked against a per-instruction reference model (LDM pending flag plus
// parked fields). Build with ID_EX_STALL_EN defined to cover the stall port.
module tb_id_ex_register;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st = 1'b0;
  logic        flush_in = 1'b0;
  logic [6:0]  EX_in = '0;
  logic [3:0]  MEM_in = '0;
  logic [2:0]  WB_in = '0;
  logic [15:0] rdata1_in = '0, rdata2_in = '0, instr_in = '0;
  logic [2:0]  rdst_in = '0, rsrc_in = '0;
  logic [6:0]  EX_out;
  logic [3:0]  MEM_out;
  logic [2:0]  WB_out;
  logic [15:0] rdata1_out, rdata2_out, imm_out;
  logic [2:0]  rdst_out, rsrc_out;
  logic        valid_out, imm_wait;

  int total = 0;
  int bad = 0;

  // reference model
  bit          m_pending;
  logic [6:0]  p_ex;
  logic [3:0]  p_mem;
  logic [2:0]  p_wb, p_rdst, p_rsrc;
  bit          e_bubble;
  logic [6:0]  e_ex;
  logic [3:0]  e_mem;
  logic [2:0]  e_wb, e_rdst, e_rsrc;
  logic [15:0] e_rd1, e_rd2, e_imm;
  logic        e_valid;

  id_ex_register dut (
    .clk(clk), .rst(rst),
`ifdef ID_EX_STALL_EN
    .stall(st),
`endif
    .flush_in(flush_in), .EX_in(EX_in), .MEM_in(MEM_in), .WB_in(WB_in),
    .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .rdst_in(rdst_in),
    .rsrc_in(rsrc_in), .instr_in(instr_in),
    .EX_out(EX_out), .MEM_out(MEM_out), .WB_out(WB_out),
    .rdata1_out(rdata1_out), .rdata2_out(rdata2_out), .imm_out(imm_out),
    .rdst_out(rdst_out), .rsrc_out(rsrc_out),
    .valid_out(valid_out), .imm_wait(imm_wait)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pending = 0; e_bubble = 0;
    p_ex = '0; p_mem = '0; p_wb = '0; p_rdst = '0; p_rsrc = '0;
    e_ex = '0; e_mem = '0; e_wb = '0; e_rdst = '0; e_rsrc = '0;
    e_rd1 = '0; e_rd2 = '0; e_imm = '0; e_valid = 1'b0;
  endtask

  // one clock edge of the instruction-level behaviour
  task automatic model_edge();
    if (st) return;
    if (m_pending) begin
      e_ex = p_ex; e_mem = p_mem; e_wb = p_wb; e_rdst = p_rdst; e_rsrc = p_rsrc;
      e_rd1 = '0; e_rd2 = '0; e_imm = instr_in; e_valid = 1'b1;
      e_bubble = 0; m_pending = 0;
    end else if (flush_in) begin
      p_ex = EX_in; p_mem = MEM_in; p_wb = WB_in; p_rdst = rdst_in; p_rsrc = rsrc_in;
      e_ex = '0; e_mem = '0; e_wb = '0; e_valid = 1'b0;
      e_bubble = 1; m_pending = 1;
    end else begin
      e_ex = EX_in; e_mem = MEM_in; e_wb = WB_in; e_rdst = rdst_in; e_rsrc = rsrc_in;
      e_rd1 = rdata1_in; e_rd2 = rdata2_in; e_valid = 1'b1;
      e_bubble = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".EX"}, 16'(EX_out), 16'(e_ex));
    chk({tag, ".MEM"}, 16'(MEM_out), 16'(e_mem));
    chk({tag, ".WB"}, 16'(WB_out), 16'(e_wb));
    chk({tag, ".valid"}, 16'(valid_out), 16'(e_valid));
    chk({tag, ".imm_wait"}, 16'(imm_wait), 16'(m_pending));
    chk({tag, ".bubble_nowrite"}, 16'(WB_out[2] | MEM_out[2]), 16'(e_bubble ? 1'b0 : (e_wb[2] | e_mem[2])));
    if (!e_bubble) begin
      chk({tag, ".rdata1"}, rdata1_out, e_rd1);
      chk({tag, ".rdata2"}, rdata2_out, e_rd2);
      chk({tag, ".imm"}, imm_out, e_imm);
      chk({tag, ".rdst"}, 16'(rdst_out), 16'(e_rdst));
      chk({tag, ".rsrc"}, 16'(rsrc_out), 16'(e_rsrc));
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic fl, input logic [6:0] ex, input logic [3:0] mem,
                       input logic [2:0] wb, input logic [2:0] rd, input logic [15:0] ins);
    flush_in = fl; EX_in = ex; MEM_in = mem; WB_in = wb; rdst_in = rd;
    rsrc_in = 3'($urandom); rdata1_in = 16'($urandom); rdata2_in = 16'($urandom);
    instr_in = ins;
  endtask

  task automatic drive_rand(input bit allow_stall);
    flush_in = ($urandom_range(0, 3) == 0);
    EX_in = 7'($urandom); MEM_in = 4'($urandom); WB_in = 3'($urandom);
    rdst_in = 3'($urandom); rsrc_in = 3'($urandom);
    rdata1_in = 16'($urandom); rdata2_in = 16'($urandom); instr_in = 16'($urandom);
`ifdef ID_EX_STALL_EN
    st = allow_stall && ($urandom_range(0, 4) == 0);
`else
    st = 1'b0 & allow_stall;
`endif
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1;
    chk("reset.valid", 16'(valid_out), 16'h0);
    chk("reset.imm_wait", 16'(imm_wait), 16'h0);
    chk("reset.EX", 16'(EX_out), 16'h0);
    chk("reset.imm", imm_out, 16'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // ADD passes straight through
    drive(1'b0, 7'b0010101, 4'b0000, 3'b101, 3'd3, 16'h0);
    step("add");
    chk("add.EX_const", 16'(EX_out), 16'h0015);
    chk("add.WB_const", 16'(WB_out), 16'h0005);
    chk("add.rdst_const", 16'(rdst_out), 16'h0003);

    // LDM: bubble then held bundle with immediate
    drive(1'b1, 7'h00, 4'b1000, 3'b110, 3'd5, 16'h0);
    step("ldm1");
    chk("ldm1.valid_const", 16'(valid_out), 16'h0);
    chk("ldm1.imm_wait_const", 16'(imm_wait), 16'h1);
    drive(1'b0, 7'h00, 4'h0, 3'h0, 3'd0, 16'h1234);
    step("ldm2");
    chk("ldm2.MEM_const", 16'(MEM_out), 16'h0008);
    chk("ldm2.WB_const", 16'(WB_out), 16'h0006);
    chk("ldm2.rdst_const", 16'(rdst_out), 16'h0005);
    chk("ldm2.imm_const", imm_out, 16'h1234);
    chk("ldm2.imm_wait_const", 16'(imm_wait), 16'h0);

    // flush and garbage control while waiting for the immediate are ignored
    drive(1'b1, 7'h22, 4'b0100, 3'b100, 3'd2, 16'h0);
    step("ign1");
    drive(1'b1, 7'b0001101, 4'b1111, 3'b111, 3'd7, 16'hA5A5);
    step("ign2");
    chk("ign2.EX_const", 16'(EX_out), 16'h0022);
    chk("ign2.imm_const", imm_out, 16'hA5A5);
    drive(1'b0, 7'h11, 4'h0, 3'b100, 3'd1, 16'h0);
    step("ign3_run");

    // asynchronous reset between edges while waiting for the immediate
    drive(1'b1, 7'h33, 4'b1000, 3'b110, 3'd6, 16'h0);
    step("rst_ldm");
    #2 rst = 1'b1;
    #1;
    chk("rstmid.valid", 16'(valid_out), 16'h0);
    chk("rstmid.imm_wait", 16'(imm_wait), 16'h0);
    chk("rstmid.MEM", 16'(MEM_out), 16'h0);
    chk("rstmid.WB", 16'(WB_out), 16'h0);
    model_reset();
    #1 rst = 1'b0;
    drive(1'b0, 7'b0010101, 4'b0000, 3'b101, 3'd3, 16'h7777);
    step("rst_add");

    // back-to-back LDMs
    drive(1'b1, 7'h05, 4'b1000, 3'b110, 3'd1, 16'h0);
    step("b2b.bub1");
    drive(1'b0, 7'h00, 4'h0, 3'h0, 3'd0, 16'h0001);
    step("b2b.ldm1");
    chk("b2b.imm1", imm_out, 16'h0001);
    drive(1'b1, 7'h06, 4'b1000, 3'b110, 3'd2, 16'h0);
    step("b2b.bub2");
    chk("b2b.bub2_valid", 16'(valid_out), 16'h0);
    drive(1'b0, 7'h00, 4'h0, 3'h0, 3'd0, 16'h0002);
    step("b2b.ldm2");
    chk("b2b.imm2", imm_out, 16'h0002);

`ifdef ID_EX_STALL_EN
    // stall freezes a pending LDM for three cycles
    drive(1'b1, 7'h44, 4'b1000, 3'b110, 3'd4, 16'h0);
    step("stall.bub");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 7'h7F, 4'hF, 3'h7, 3'd7, 16'(i));
      st = 1'b1;
      step("stall.hold");
      chk("stall.imm_wait_const", 16'(imm_wait), 16'h1);
    end
    st = 1'b0;
    drive(1'b0, 7'h00, 4'h0, 3'h0, 3'd0, 16'hBEEF);
    step("stall.release");
    chk("stall.imm_const", imm_out, 16'hBEEF);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive_rand(1'b1);
      step("rand");
    end
    st = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
